stack_engine: RTL and testbench
===============================

Name: stack_engine

Overview:
- Memory-side stack writer/reader for the 8-bit processor. It completes the push/pop/call/ret data paths by driving the memory interface in the write direction as well as the read direction.
- The processor issues single commands over a valid/ready handshake. The engine owns the stack pointer (SP), performs the memory access, and returns a one-cycle response.
- The memory read timing is unchanged: address plus strobe at one edge, read data valid from the next cycle.

Parameters:
- SP_RESET, 8'h00: SP value after reset. The first push writes address 8'hFF.
- DEPTH_MAX, 64: maximum number of bytes on the stack (1..256). Used for overflow and underflow detection.

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- cmdValid  in  1  command present
- cmdReady  out  1  engine idle and able to accept a command
- cmd  in  2  0=PUSH, 1=POP, 2=LOAD_SP, 3=GET_SP
- cmdData  in  8  push byte (PUSH) or new SP (LOAD_SP); ignored otherwise
- respValid  out  1  one-cycle completion pulse
- respData  out  8  popped byte (POP), SP (GET_SP), otherwise 0
- respError  out  1  valid with respValid; overflow or underflow
- memAddr  out  8  memory address
- memDataWrite  out  8  memory write data
- memWrite  out  1  write strobe; memory stores memDataWrite at memAddr on this edge
- memStrobe  out  1  read strobe; memDataRead valid the following cycle
- memDataRead  in  8  memory read data
- sp  out  8  current stack pointer
- depth  out  9  current number of bytes on the stack (0..DEPTH_MAX)

Behaviour:
- Reset values: sp=SP_RESET, depth=0, state=IDLE, cmdReady=1, respValid=0, respError=0, respData=0, memWrite=0, memStrobe=0, memAddr=0, memDataWrite=0.
- Reset mid-operation: the pending command is dropped, no response is produced, and no memory strobe is asserted after the reset edge.
- Handshake: a command is accepted on an edge where cmdValid & cmdReady. cmdReady=1 only in IDLE. cmd and cmdData are latched at acceptance. While busy, cmdValid is ignored and the processor must hold its command.
- Stack direction: full-descending. PUSH pre-decrements SP then writes. POP reads at SP then post-increments. SP arithmetic is mod 256: 8'h00-1 = 8'hFF and 8'hFF+1 = 8'h00. Wrap alone is not an error.
- States: IDLE, WRITE, READ, CAPTURE, RESP.
- IDLE, on acceptance:
  - PUSH with depth<DEPTH_MAX: sp<=sp-1, depth<=depth+1, go to WRITE.
  - PUSH with depth==DEPTH_MAX: respError=1, no memory access, sp/depth unchanged, go to RESP.
  - POP with depth>0: go to READ.
  - POP with depth==0: respError=1, respData=0, no memory access, go to RESP.
  - LOAD_SP: sp<=cmdData, depth<=0, go to RESP.
  - GET_SP: respData<=sp, go to RESP.
- WRITE: memAddr=sp (already decremented), memDataWrite=latched byte, memWrite=1 for exactly one cycle. Go to RESP.
- READ: memAddr=sp, memStrobe=1 for exactly one cycle. Go to CAPTURE.
- CAPTURE: respData<=memDataRead, sp<=sp+1, depth<=depth-1. Go to RESP.
- RESP: respValid=1 for exactly one cycle, respData/respError stable. Go to IDLE; cmdReady=1 the following cycle.
- Latency, measured from the accept edge to the cycle in which respValid is high:
  - PUSH: 2 cycles.
  - POP: 3 cycles.
  - LOAD_SP, GET_SP, and error cases: 1 cycle.
  - Back-to-back throughput is one command per latency+1 cycles.
- memWrite and memStrobe are never high in the same cycle. Neither is asserted in IDLE or RESP.
- respData=0 and respError=0 for successful PUSH and LOAD_SP.
- All outputs are registered. No combinational path from cmdValid to cmdReady.

Test Plan:
- Reset, PUSH 8'hA5: WRITE cycle shows memAddr=FF, memDataWrite=A5, memWrite=1. respValid 2 cycles after accept, respError=0. Afterwards sp=FF, depth=1.
- PUSH 11, PUSH 22, POP, POP: writes land at FF then FE. First pop reads FE with one-cycle strobe and returns 22; second returns 11. Final sp=00, depth=0.
- POP on an empty stack after reset: respValid 1 cycle after accept, respError=1, respData=0. memStrobe never asserted, sp=00.
- DEPTH_MAX=2: three PUSHes; the third returns respError=1 with no memWrite, sp=FE, depth=2.
- LOAD_SP 8'h10 then GET_SP: respData=10, depth=0. Then PUSH 7E writes address 0F.
- Assert reset during the READ cycle of a POP: no respValid and no further strobes; sp=SP_RESET, depth=0, cmdReady=1 in the cycle after reset deasserts.

Source files
------------

// File: rtl/stack_engine.sv
// Full-descending byte stack engine: owns SP/depth and drives memory write and read strobes
// for PUSH/POP, plus LOAD_SP/GET_SP, over a valid/ready command handshake.
module stack_engine #(
  parameter logic [7:0]  SP_RESET  = 8'h00,
  parameter int unsigned DEPTH_MAX = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic [1:0] cmd,
  input  logic [7:0] cmdData,
  output logic       respValid,
  output logic [7:0] respData,
  output logic       respError,
  output logic [7:0] memAddr,
  output logic [7:0] memDataWrite,
  output logic       memWrite,
  output logic       memStrobe,
  input  logic [7:0] memDataRead,
  output logic [7:0] sp,
  output logic [8:0] depth
);

  localparam logic [8:0] DepthMax = 9'(DEPTH_MAX);

  localparam logic [1:0] CmdPush   = 2'd0;
  localparam logic [1:0] CmdPop    = 2'd1;
  localparam logic [1:0] CmdLoadSp = 2'd2;
  localparam logic [1:0] CmdGetSp  = 2'd3;

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StCapture, StResp} state_e;

  state_e     stateQ, stateD;
  logic [7:0] spQ, spD;
  logic [8:0] depthQ, depthD;
  logic [7:0] memAddrQ, memAddrD;
  logic [7:0] memDataWriteQ, memDataWriteD;
  logic [7:0] respDataQ, respDataD;
  logic       respErrorQ, respErrorD;
  logic       cmdReadyQ, memWriteQ, memStrobeQ, respValidQ;
  logic       accept;

  assign accept = cmdValid & cmdReadyQ;

  always_comb begin
    stateD        = stateQ;
    spD           = spQ;
    depthD        = depthQ;
    memAddrD      = memAddrQ;
    memDataWriteD = memDataWriteQ;
    respDataD     = respDataQ;
    respErrorD    = respErrorQ;

    unique case (stateQ)
      StIdle: begin
        if (accept) begin
          respDataD  = 8'h00;
          respErrorD = 1'b0;
          unique case (cmd)
            CmdPush: begin
              if (depthQ < DepthMax) begin
                // Pre-decrement: the write address is the new SP.
                spD           = spQ - 8'd1;
                depthD        = depthQ + 9'd1;
                memAddrD      = spQ - 8'd1;
                memDataWriteD = cmdData;
                stateD        = StWrite;
              end else begin
                respErrorD = 1'b1;
                stateD     = StResp;
              end
            end
            CmdPop: begin
              if (depthQ != 9'd0) begin
                memAddrD = spQ;
                stateD   = StRead;
              end else begin
                respErrorD = 1'b1;
                stateD     = StResp;
              end
            end
            CmdLoadSp: begin
              spD    = cmdData;
              depthD = 9'd0;
              stateD = StResp;
            end
            CmdGetSp: begin
              respDataD = spQ;
              stateD    = StResp;
            end
          endcase
        end
      end
      StWrite: stateD = StResp;
      StRead:  stateD = StCapture;
      StCapture: begin
        respDataD = memDataRead;
        spD       = spQ + 8'd1;
        depthD    = depthQ - 9'd1;
        stateD    = StResp;
      end
      StResp: begin
        respDataD  = 8'h00;
        respErrorD = 1'b0;
        stateD     = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  // Strobes and ready are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ        <= StIdle;
      spQ           <= SP_RESET;
      depthQ        <= 9'd0;
      memAddrQ      <= 8'h00;
      memDataWriteQ <= 8'h00;
      respDataQ     <= 8'h00;
      respErrorQ    <= 1'b0;
      cmdReadyQ     <= 1'b1;
      memWriteQ     <= 1'b0;
      memStrobeQ    <= 1'b0;
      respValidQ    <= 1'b0;
    end else begin
      stateQ        <= stateD;
      spQ           <= spD;
      depthQ        <= depthD;
      memAddrQ      <= memAddrD;
      memDataWriteQ <= memDataWriteD;
      respDataQ     <= respDataD;
      respErrorQ    <= respErrorD;
      cmdReadyQ     <= (stateD == StIdle);
      memWriteQ     <= (stateD == StWrite);
      memStrobeQ    <= (stateD == StRead);
      respValidQ    <= (stateD == StResp);
    end
  end

  assign cmdReady     = cmdReadyQ;
  assign respValid    = respValidQ;
  assign respData     = respDataQ;
  assign respError    = respErrorQ;
  assign memAddr      = memAddrQ;
  assign memDataWrite = memDataWriteQ;
  assign memWrite     = memWriteQ;
  assign memStrobe    = memStrobeQ;
  assign sp           = spQ;
  assign depth        = depthQ;

endmodule

// File: tb/tb_stack_engine.sv
// Randomized bench for stack_engine: a byte-array stack model predicts responses, latency and
// memory traffic for each command; a behavioural RAM serves the DUT's memory port.
module tb_stack_engine;

  localparam int unsigned DMax = 4;
  localparam logic [7:0]  SpRst = 8'h00;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmdValid;
  logic       cmdReady;
  logic [1:0] cmd;
  logic [7:0] cmdData;
  logic       respValid;
  logic [7:0] respData;
  logic       respError;
  logic [7:0] memAddr;
  logic [7:0] memDataWrite;
  logic       memWrite;
  logic       memStrobe;
  logic [7:0] memDataRead;
  logic [7:0] sp;
  logic [8:0] depth;

  int nChecks = 0;
  int nFails  = 0;

  logic [7:0] ram  [256];
  logic [7:0] mMem [256];
  logic [7:0] mSp;
  int         mDepth;

  stack_engine #(
    .SP_RESET (SpRst),
    .DEPTH_MAX(DMax)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmdValid    (cmdValid),
    .cmdReady    (cmdReady),
    .cmd         (cmd),
    .cmdData     (cmdData),
    .respValid   (respValid),
    .respData    (respData),
    .respError   (respError),
    .memAddr     (memAddr),
    .memDataWrite(memDataWrite),
    .memWrite    (memWrite),
    .memStrobe   (memStrobe),
    .memDataRead (memDataRead),
    .sp          (sp),
    .depth       (depth)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memWrite) ram[memAddr] <= memDataWrite;
    if (memStrobe) memDataRead <= ram[memAddr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic doCmd(input logic [1:0] c, input logic [7:0] d);
    int         expLat, expW, expS, lat, nW, nS;
    logic       expErr;
    logic [7:0] expData, expAddr, wAddr, wData, sAddr;
    bit         done;
    expErr = 1'b0; expData = 8'h00; expW = 0; expS = 0; expAddr = 8'h00; expLat = 1;
    wAddr = 8'h00; wData = 8'h00; sAddr = 8'h00;
    case (c)
      2'd0: if (mDepth < int'(DMax)) begin
        mSp = mSp - 8'd1;
        mDepth++;
        mMem[mSp] = d;
        expW = 1; expAddr = mSp; expLat = 2;
      end else expErr = 1'b1;
      2'd1: if (mDepth > 0) begin
        expS = 1; expAddr = mSp; expData = mMem[mSp];
        mSp = mSp + 8'd1;
        mDepth--;
        expLat = 3;
      end else expErr = 1'b1;
      2'd2: begin mSp = d; mDepth = 0; end
      default: expData = mSp;
    endcase

    for (int i = 0; i < 10 && !cmdReady; i++) @(negedge clk);
    check("ready_before", 32'(cmdReady), 1);
    cmdValid = 1'b1; cmd = c; cmdData = d;
    @(posedge clk);
    #1;
    cmdValid = 1'b0; cmd = 2'($urandom_range(0, 3)); cmdData = 8'($urandom);

    lat = 0; nW = 0; nS = 0; done = 1'b0;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
      if (memWrite) begin nW++; wAddr = memAddr; wData = memDataWrite; end
      if (memStrobe) begin nS++; sAddr = memAddr; end
      check("wr_rd_exclusive", 32'(memWrite & memStrobe), 0);
      check("busy_not_ready", 32'(cmdReady), 0);
      if (respValid) begin
        done = 1'b1;
        check("no_strobe_in_resp", 32'(memWrite | memStrobe), 0);
      end
    end
    check("latency", lat, expLat);
    check("resp_error", 32'(respError), 32'(expErr));
    check("resp_data", 32'(respData), 32'(expData));
    check("write_count", nW, expW);
    check("strobe_count", nS, expS);
    if (expW == 1) begin
      check("write_addr", 32'(wAddr), 32'(expAddr));
      check("write_data", 32'(wData), 32'(d));
    end
    if (expS == 1) check("read_addr", 32'(sAddr), 32'(expAddr));
    check("sp", 32'(sp), 32'(mSp));
    check("depth", 32'(depth), 32'(mDepth));
    @(negedge clk);
    check("resp_one_cycle", 32'(respValid), 0);
    check("ready_after", 32'(cmdReady), 1);
  endtask

  task automatic resetDuringPop();
    doCmd(2'd0, 8'h5C);
    @(negedge clk);
    cmdValid = 1'b1; cmd = 2'd1;
    @(posedge clk);
    #1 cmdValid = 1'b0;
    @(negedge clk);
    check("rst_in_read_cycle", 32'(memStrobe), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mSp = SpRst; mDepth = 0;
    @(negedge clk);
    check("rst_sp", 32'(sp), 32'(SpRst));
    check("rst_depth", 32'(depth), 0);
    check("rst_ready", 32'(cmdReady), 1);
    for (int i = 0; i < 4; i++) begin
      check("rst_no_resp", 32'(respValid), 0);
      check("rst_no_strobe", 32'(memStrobe | memWrite), 0);
      @(negedge clk);
    end
  endtask

  initial begin
    int r;
    logic [1:0] c;
    reset = 1'b1; cmdValid = 1'b0; cmd = 2'd0; cmdData = 8'h00;
    mSp = SpRst; mDepth = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(cmdReady), 1);
    check("reset_resp", {29'd0, respValid, respError, memWrite}, 0);
    check("reset_strobe", 32'(memStrobe), 0);
    check("reset_data", {respData, memAddr, memDataWrite}, 0);
    check("reset_sp", 32'(sp), 32'(SpRst));
    check("reset_depth", 32'(depth), 0);
    reset = 1'b0;
    @(negedge clk);

    doCmd(2'd1, 8'h00);                      // underflow on empty stack
    doCmd(2'd0, 8'hA5);                      // first push lands at FF
    doCmd(2'd1, 8'h00);
    doCmd(2'd0, 8'h11);
    doCmd(2'd0, 8'h22);
    doCmd(2'd1, 8'h00);
    doCmd(2'd1, 8'h00);
    for (int i = 0; i < 5; i++) doCmd(2'd0, 8'(8'h30 + i));  // fifth push overflows
    doCmd(2'd2, 8'h10);
    doCmd(2'd3, 8'h00);
    doCmd(2'd0, 8'h7E);                      // writes 0F
    resetDuringPop();

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      c = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      doCmd(c, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
